// File: rtl/rr_sel_arbiter_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin select arbiter.
package rr_arb_pkg;
    typedef enum logic {IDLE, GRANT} state_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if: request/release inputs and mux select/grant outputs of the arbiter.
interface rr_sel_arbiter_if #(parameter int N = 4, parameter int SEL_W = 2) ();
    logic [N-1:0]     req;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     gnt;
    logic             valid;
    modport master (output req, done, input sel, gnt, valid);
    modport slave  (input req, done, output sel, gnt, valid);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request bit searching upward from ptr, wrapping at N.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        // scan farthest-first so the nearest hit to ptr is the last write
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                found = 1'b1;
                idx   = SEL_W'(j);
            end
        end
    end
endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter holding each grant until released, driving an N:1 mux select.
module rr_sel_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input logic             clk,
    input logic             rst,
    rr_sel_arbiter_if.slave bus
);
    localparam int HW = (MAX_HOLD < 2) ? 1 : clog2(MAX_HOLD);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    generate
        if (SEL_W != clog2(N)) begin : g_bad_sel_w
            $error("rr_sel_arbiter: SEL_W must equal clog2(N)");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, nxt_ptr, pick_ptr, idx;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             valid_q, valid_d, found, rel, timeout;

    assign timeout = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1));

    rr_priority_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (idx)
    );

    // a release re-arbitrates in the same cycle using the advanced pointer
    always_comb begin
        nxt_ptr  = (sel_q == LAST) ? '0 : sel_q + 1'b1;
        rel      = (state_q == GRANT) && (bus.done || !bus.req[sel_q] || timeout);
        pick_ptr = rel ? nxt_ptr : ptr_q;
        ptr_d    = rel ? nxt_ptr : ptr_q;
        state_d  = state_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        hold_d   = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        if (state_q == IDLE || rel) begin
            hold_d  = '0;
            state_d = found ? GRANT : IDLE;
            sel_d   = found ? idx : sel_q;
            gnt_d   = found ? (N'(1) << idx) : '0;
            valid_d = found;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed steps with hand-computed sel/gnt/valid after each clock.
module tb_rr_sel_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    rr_sel_arbiter_if #(.N(4), .SEL_W(2)) bus ();

    rr_sel_arbiter #(.N(4), .SEL_W(2), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic [1:0] es, input logic [3:0] eg);
        checks++;
        assert (bus.valid === ev) else begin
            failures++;
            $error("FAIL %s valid: got %b want %b", tag, bus.valid, ev);
        end
        checks++;
        assert (bus.sel === es) else begin
            failures++;
            $error("FAIL %s sel: got %0d want %0d", tag, bus.sel, es);
        end
        checks++;
        assert (bus.gnt === eg) else begin
            failures++;
            $error("FAIL %s gnt: got %b want %b", tag, bus.gnt, eg);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.done = 1'b0;
        step(); chk("rst_c1", 0, 0, 4'b0000);
        step(); chk("rst_c2", 0, 0, 4'b0000);
        rst = 1'b0;
        step(); chk("first", 1, 0, 4'b0001);
        bus.done = 1'b1;
        step(); chk("rr1", 1, 1, 4'b0010);
        step(); chk("rr2", 1, 2, 4'b0100);
        step(); chk("rr3", 1, 3, 4'b1000);
        step(); chk("rr_wrap", 1, 0, 4'b0001);
        bus.req = 4'b0100;
        step(); chk("to_ptr3_a", 1, 2, 4'b0100);
        bus.req = 4'b0101;
        step(); chk("sparse_p3", 1, 0, 4'b0001);
        step(); chk("sparse_2", 1, 2, 4'b0100);
        step(); chk("sparse_0", 1, 0, 4'b0001);
        bus.done = 1'b0;
        bus.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step(); chk("hold_s0", 1, 0, 4'b0001);
        end
        for (int i = 0; i < 4; i++) begin
            step(); chk("hold_s1", 1, 1, 4'b0010);
        end
        step(); chk("timeout_s0", 1, 0, 4'b0001);
        bus.req = 4'b0100;
        step(); chk("drop_to2", 1, 2, 4'b0100);
        bus.req = 4'b0000;
        step(); chk("idle", 0, 2, 4'b0000);
        bus.done = 1'b1;
        step(); chk("idle_done", 0, 2, 4'b0000);
        bus.done = 1'b0;
        bus.req = 4'b1000;
        step(); chk("idle_to3", 1, 3, 4'b1000);
        bus.req = 4'b0010;
        step(); chk("s1", 1, 1, 4'b0010);
        bus.done = 1'b1;
        step(); chk("sole_rewin", 1, 1, 4'b0010);
        bus.done = 1'b0;
        step(); chk("s1_hold", 1, 1, 4'b0010);
        rst = 1'b1;
        bus.req = 4'b0011;
        step(); chk("midrst", 0, 0, 4'b0000);
        rst = 1'b0;
        bus.req = 4'b0110;
        step(); chk("rst_ptr", 1, 1, 4'b0010);
        rst = 1'b1;
        step(); chk("rst2", 0, 0, 4'b0000);
        rst = 1'b0;
        bus.req = 4'b0011;
        step(); chk("post_rst", 1, 0, 4'b0001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
